// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter that
//                multiplexes the cpu MEM stage and the debug/loader port onto
//                a single dmem port.
//                Contents: arbiter state enum, grant enum, default starvation
//                limit and the width of the wait counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter FSM: ACK is the single cycle following a debug grant.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } arb_state_e;

  // Owner of the dmem port in the current cycle.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2
  } arb_gnt_e;

  // Blocked debug cycles tolerated before debug overrides the cpu.
  localparam int unsigned c_starve_limit_dflt = 4;

  // Wide enough for the largest legal limit (15).
  localparam int unsigned c_wait_cnt_w = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the cpu request port, debug request port and the
//                single dmem port handled by mem_arbiter.
//                slave  : arbiter view (takes requests, drives dmem port)
//                master : environment view (cpu, debug agent, dmem)
//  Ports (signals):
//    cpu_req/cpu_we/cpu_addr/cpu_wdata  cpu MEM-stage request
//    cpu_rdata/cpu_stall                cpu load data and pipeline freeze
//    dbg_req/dbg_we/dbg_addr/dbg_wdata  debug request, held until dbg_ack
//    dbg_rdata/dbg_ack                  registered debug read data, done pulse
//    mem_wr_en/mem_addr/mem_wr_data     dmem port driven by the arbiter
//    mem_rd_data                        dmem combinational read data
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;

  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_wr_en, mem_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_wr_en, mem_addr, mem_wr_data,
    output mem_rd_data
  );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_wait_counter
//  Description : Saturating up-counter of blocked debug cycles. Clear has
//                priority over increment; the count stops at LIMIT.
//  Ports:
//    clk        system clock
//    rst        synchronous active-low reset
//    i_inc      count one blocked cycle
//    i_clr      return to zero
//    o_at_limit count has reached LIMIT
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_wait_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [WIDTH-1:0] c_limit = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == c_limit);

endmodule : arb_wait_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Single-port dmem arbiter between the cpu MEM stage and a
//                debug/loader port. The cpu normally wins; a debug request
//                wins when the cpu is idle or after STARVE_LIMIT blocked
//                cycles. A debug access takes one grant cycle plus one ACK
//                cycle; the cpu is stalled only in the debug grant cycle.
//  Ports:
//    clk  system clock
//    rst  synchronous active-low reset
//    bus  mem_arbiter_if.slave (cpu port, debug port, dmem port)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = c_starve_limit_dflt
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus
);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  arb_gnt_e    w_gnt;
  logic        w_at_limit;
  logic        w_cnt_inc;
  logic        w_cnt_clr;
  logic [31:0] r_dbg_rdata;

  // Grant and next state. Holding reset forces "no grant" so the dmem port
  // stays quiet even while the state register still carries stale values.
  always_comb begin
    w_gnt       = NONE;
    w_state_nxt = r_state;
    if (rst) begin
      case (r_state)
        IDLE: begin
          if (bus.dbg_req && (!bus.cpu_req || w_at_limit)) begin
            w_gnt       = DBG;
            w_state_nxt = ACK;
          end else if (bus.cpu_req) begin
            w_gnt = CPU;
          end
        end
        ACK: begin
          // Debug cannot win here, so a held dbg_req is not re-granted.
          if (bus.cpu_req) begin
            w_gnt = CPU;
          end
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Only blocked IDLE cycles count; an aborted request leaves the count as is.
  assign w_cnt_inc = rst && (r_state == IDLE) && bus.dbg_req && (w_gnt != DBG);
  assign w_cnt_clr = (w_gnt == DBG);

  arb_wait_counter #(
    .WIDTH (c_wait_cnt_w),
    .LIMIT (STARVE_LIMIT)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_cnt_inc),
    .i_clr      (w_cnt_clr),
    .o_at_limit (w_at_limit)
  );

  // dmem port mux: the idle port is driven to zero.
  always_comb begin
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    case (w_gnt)
      CPU: begin
        bus.mem_wr_en   = bus.cpu_we;
        bus.mem_addr    = bus.cpu_addr;
        bus.mem_wr_data = bus.cpu_wdata;
      end
      DBG: begin
        bus.mem_wr_en   = bus.dbg_we;
        bus.mem_addr    = bus.dbg_addr;
        bus.mem_wr_data = bus.dbg_wdata;
      end
      default: ;
    endcase
  end

  // Debug read data is captured at the edge closing its grant cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dbg_rdata <= '0;
    end else if ((w_gnt == DBG) && !bus.dbg_we) begin
      r_dbg_rdata <= bus.mem_rd_data;
    end
  end

  assign bus.cpu_rdata = bus.mem_rd_data;
  assign bus.cpu_stall = bus.cpu_req && (w_gnt == DBG);
  // Gated by rst so a reset landing on the ACK cycle swallows the pulse.
  assign bus.dbg_ack   = rst && (r_state == ACK);
  assign bus.dbg_rdata = rst ? r_dbg_rdata : 32'd0;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A reference model of
//                the arbitration rules predicts every cycle's dmem port,
//                stall and ack; debug completions are queued and checked by
//                a separate monitor when dbg_ack is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural dmem: unwritten words read a fixed pattern of their index.
  function automatic logic [31:0] init_word(input int idx);
    return 32'hA500_0000 ^ (32'(idx) * 32'h0101_0101);
  endfunction

  logic [31:0] mem     [0:63];
  bit          written [0:63];
  assign bus.mem_rd_data = written[bus.mem_addr[7:2]] ? mem[bus.mem_addr[7:2]]
                                                       : init_word(int'(bus.mem_addr[7:2]));
  always @(posedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      mem[bus.mem_addr[7:2]]     <= bus.mem_wr_data;
      written[bus.mem_addr[7:2]] <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:63];
  int          waited;
  bit          ack_next;
  bit          was_ack;
  logic [31:0] last_rd;
  logic [31:0] exp_q [$];

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check combinational outputs, advance model.
  task automatic step(input bit r, input bit cr, input bit cw,
                      input logic [31:0] ca, input logic [31:0] cd,
                      input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] dd);
    bit          in_ack, dbg_win, cpu_win, ewe;
    logic [31:0] ea, ed;
    @(negedge clk);
    rst = r;
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
    #1;
    in_ack  = r && ack_next;
    dbg_win = r && !ack_next && dr && (!cr || waited >= LIMIT);
    cpu_win = r && cr && !dbg_win;
    ewe = 1'b0; ea = 32'd0; ed = 32'd0;
    if (dbg_win) begin
      ewe = dw; ea = da; ed = dd;
    end else if (cpu_win) begin
      ewe = cw; ea = ca; ed = cd;
    end
    check("mem_wr_en",   {31'd0, bus.mem_wr_en}, {31'd0, ewe});
    check("mem_addr",    bus.mem_addr, ea);
    check("mem_wr_data", bus.mem_wr_data, ed);
    check("cpu_stall",   {31'd0, bus.cpu_stall}, {31'd0, cr && dbg_win});
    check("cpu_rdata",   bus.cpu_rdata, ref_mem[ea[7:2]]);
    check("dbg_ack",     {31'd0, bus.dbg_ack}, {31'd0, in_ack});
    check("dbg_rdata_hold", bus.dbg_rdata, r ? last_rd : 32'd0);
    @(posedge clk);
    if (!r) begin
      ack_next = 1'b0;
      waited   = 0;
      last_rd  = 32'd0;
      exp_q.delete();
    end else begin
      if (dbg_win) begin
        waited = 0;
        if (!dw) last_rd = ref_mem[da[7:2]];
        exp_q.push_back(last_rd);
      end else if (!ack_next && dr) begin
        waited = (waited < LIMIT) ? waited + 1 : LIMIT;
      end
      if (ewe) ref_mem[ea[7:2]] = ed;
      ack_next = dbg_win;
    end
    was_ack = in_ack;
  endtask

  task automatic idle_step(input bit r);
    step(r, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Monitor: every dbg_ack must match a queued completion.
  logic [31:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.dbg_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL dbg_ack_unexpected: got ack=1 required no completion pending at %0t", $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("dbg_rdata_ack", bus.dbg_rdata, mon_exp);
        end
      end
    end
  end

  // Random debug agent state
  bit          d_act;
  bit          d_we;
  logic [31:0] d_addr, d_data;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    waited = 0; ack_next = 1'b0; was_ack = 1'b0; last_rd = 32'd0;
    rst = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

    // Reset state
    idle_step(1'b0);
    idle_step(1'b0);

    // cpu write, no debug
    step(1, 1, 1, 32'h20, 32'hDEADBEEF, 0, 0, 0, 0);
    // place 0x1234 at 0x40, then debug read with cpu idle
    step(1, 1, 1, 32'h40, 32'h1234, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 32'h40, 0);
    step(1, 0, 0, 0, 0, 1, 0, 32'h40, 0);
    idle_step(1'b1);

    // starvation: cpu busy, debug read of 0x20 wins after LIMIT cycles
    for (int k = 0; k < LIMIT + 2; k++)
      step(1, 1, 0, 32'h8, 0, 1, 0, 32'h20, 0);
    idle_step(1'b1);

    // debug write held through ACK: second grant only in the next IDLE cycle
    for (int k = 0; k < 4; k++)
      step(1, 0, 0, 0, 0, 1, 1, 32'h44, 32'hCAFE0000 + 32'(k));
    idle_step(1'b1);

    // reset landing on the ACK cycle
    step(1, 0, 0, 0, 0, 1, 0, 32'h20, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h20, 0);
    idle_step(1'b1);

    // abort after 2 blocked cycles, count held, then resumes from 2
    step(1, 1, 0, 32'h4, 0, 1, 0, 32'h48, 0);
    step(1, 1, 0, 32'h4, 0, 1, 0, 32'h48, 0);
    step(1, 1, 0, 32'h4, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h4, 0, 0, 0, 0, 0);
    for (int k = 0; k < LIMIT; k++)
      step(1, 1, 0, 32'h4, 0, 1, 0, 32'h48, 0);
    idle_step(1'b1);

    // Randomized traffic
    d_act = 1'b0; d_we = 1'b0; d_addr = '0; d_data = '0;
    for (int i = 0; i < 800; i++) begin
      bit          r, cr, cw;
      logic [31:0] ca, cd;
      r  = ($urandom_range(0, 49) != 0);
      cr = ($urandom_range(0, 9) < 6);
      cw = $urandom_range(0, 1) == 1;
      ca = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      cd = $urandom;
      if (d_act && was_ack) d_act = 1'b0;
      if (!d_act && $urandom_range(0, 3) == 0) begin
        d_act  = 1'b1;
        d_we   = $urandom_range(0, 1) == 1;
        d_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        d_data = $urandom;
      end else if (d_act && !ack_next && $urandom_range(0, 15) == 0) begin
        d_act = 1'b0;
      end
      step(r, cr, cw, ca, cd, d_act, d_we, d_addr, d_data);
    end

    for (int k = 0; k < 3; k++) idle_step(1'b1);
    check("pending_completions", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL be the count of consecutive blocked dbg cycles after which dbg wins over cpu (legal range 1..15).
REQ-002 Reset rst, synchronous, active-low; clock clk.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-low reset.
REQ-005 cpu_req, cpu_we  input  1 each  MEM-stage access request and write enable.
REQ-006 cpu_addr, cpu_wdata  input  32 each  MEM-stage address and store data.
REQ-007 cpu_rdata  output  32  load data, combinational pass-through of mem_rd_data.
REQ-008 cpu_stall  output  1  freezes the cpu pipeline this cycle.
REQ-009 dbg_req, dbg_we  input  1 each  debug/loader request and write enable; held with stable fields until dbg_ack.
REQ-010 dbg_addr, dbg_wdata  input  32 each  debug address and write data.
REQ-011 dbg_rdata  output  32  registered read data for the debug port.
REQ-012 dbg_ack  output  1  one-cycle completion pulse.
REQ-013 mem_wr_en  output  1, mem_addr, mem_wr_data  output  32 each  single dmem port.
REQ-014 mem_rd_data  input  32  dmem combinational read data.

Function
REQ-015 Exactly one requester or none SHALL be granted per cycle; grant is combinational from inputs and registered state.
REQ-016 States: IDLE, ACK; IDLE->ACK on dbg grant; ACK->IDLE unconditionally next cycle.
REQ-017 In IDLE: dbg granted if dbg_req && (!cpu_req || wait_cnt == STARVE_LIMIT); else cpu granted if cpu_req.
REQ-018 In ACK: dbg SHALL NOT be granted; cpu granted if cpu_req; dbg_ack = 1.
REQ-019 wait_cnt SHALL increment, saturating at STARVE_LIMIT, each IDLE cycle with dbg_req high and dbg not granted; cleared to 0 on dbg grant; held otherwise.
REQ-020 cpu_stall SHALL equal cpu_req && dbg granted; never asserted in ACK or when cpu is granted.
REQ-021 Granted side drives mem_addr, mem_wr_data, mem_wr_en = granted we; no grant: mem_wr_en = 0, mem_addr = 0, mem_wr_data = 0.
REQ-022 On dbg grant with dbg_we = 0, dbg_rdata SHALL load mem_rd_data at the clock edge ending the grant cycle; dbg write leaves dbg_rdata unchanged.
REQ-023 Latency: dbg access completes with dbg_ack exactly 1 cycle after grant; cpu access completes in its grant cycle (0 added latency).
REQ-024 Worst-case dbg wait under continuous cpu_req SHALL be STARVE_LIMIT cycles; cpu stall per dbg access exactly 1 cycle.
REQ-025 dbg_req dropping before grant SHALL abort with no access; wait_cnt holds its value.

Reset
REQ-026 While rst = 0: state IDLE, wait_cnt 0, dbg_ack 0, dbg_rdata 0, mem_wr_en 0, cpu_stall 0, no grant.
REQ-027 Reset in the grant or ACK cycle SHALL suppress the pending dbg_ack; requester re-issues after reset.
REQ-028 First cycle after rst = 1 SHALL arbitrate normally from IDLE.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum (IDLE, ACK), grant enum (NONE, CPU, DBG), and default STARVE_LIMIT.
REQ-030 Sub-module arb_wait_counter (saturating counter, inc/clr/limit) is the one natural sub-block; remaining logic flat in mem_arbiter.

Verification
REQ-031 cpu_req=1, cpu_we=1, addr 0x20, wdata 0xDEADBEEF, no dbg -> mem_wr_en=1, mem_addr 0x20, cpu_stall=0 same cycle.
REQ-032 dbg read addr 0x40 (mem holds 0x1234), cpu idle -> granted cycle 0, dbg_ack=1 and dbg_rdata=0x1234 in cycle 1.
REQ-033 cpu_req held high, dbg_req raised, STARVE_LIMIT=4 -> cpu wins 4 cycles, dbg granted cycle 5 with cpu_stall=1, cpu regranted in ACK cycle.
REQ-034 dbg_req held high through ACK -> no second grant in ACK; regrant earliest next IDLE cycle.
REQ-035 rst=0 asserted during ACK cycle -> dbg_ack=0, dbg_rdata=0, mem_wr_en=0 next cycle.
REQ-036 dbg_req pulsed 2 cycles then dropped under cpu load -> no dbg access, wait_cnt=2 held, no ack.
